k16_alu_sequencer: RTL and testbench

Command sequencer between the K16 decode stage and the K16Alu combinational ALU. It accepts one command per handshake and drives the ALU operand, carry and opcode inputs. Multi-bit shifts are performed by iterating the ALU's single-bit shift, feeding each result and carry back into the ALU. It owns the architectural C/Z/N flag register, so ADC/ROL/ROR carry chains span consecutive commands.

---
 rtl/k16_alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_k16_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/k16_alu_sequencer.sv
// k16_alu_sequencer
//   Command sequencer between K16 decode and the combinational K16Alu.
//   Accepts one command per cmdValid/cmdReady handshake. It drives the ALU
//   from working registers and returns the registered result and flags on a
//   resValid/resReady handshake. Multi-bit shifts iterate the ALU's
//   single-bit shift, feeding result and carry back each cycle. The C/Z/N
//   flags are architectural, so carry chains span consecutive commands.
//
//   Ports:
//     clk, reset                     clock, async active-high reset
//     cmdValid/cmdReady              command handshake
//     cmdType/cmdOp/cmdA/cmdB        command type, op, operands
//     cmdCount                       shift iterations (SHIFT_OP only)
//     cmdCarryLoad/cmdCarry          preset C before execution
//     resValid/resReady              result handshake
//     result, flagC/flagZ/flagN      registered result and flag register
//     alu*                           operands/opcode to and results from K16Alu
//
//   Optional feature: define K16_SEQ_BACKTOBACK_EN to accept the next command
//   in the same cycle the result is handed off (no IDLE bubble).
//
//   Type/op encodings default below; a real K16Alu define header included
//   earlier takes precedence.

`ifndef ALU_OP
`define ALU_OP   3'd0
`endif
`ifndef SHIFT_OP
`define SHIFT_OP 3'd1
`endif
`ifndef LOAD_OP
`define LOAD_OP  3'd2
`endif
`ifndef COPY_OP
`define COPY_OP  3'd0
`endif

module k16_alu_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmdValid,
   output logic             cmdReady,
   input  logic [2:0]       cmdType,
   input  logic [2:0]       cmdOp,
   input  logic [WIDTH-1:0] cmdA,
   input  logic [WIDTH-1:0] cmdB,
   input  logic [CNT_W-1:0] cmdCount,
   input  logic             cmdCarryLoad,
   input  logic             cmdCarry,
   output logic             resValid,
   input  logic             resReady,
   output logic [WIDTH-1:0] result,
   output logic             flagC,
   output logic             flagZ,
   output logic             flagN,
   output logic [WIDTH-1:0] aluOperand1,
   output logic [WIDTH-1:0] aluOperand2,
   output logic             aluCarryIn,
   output logic [2:0]       aluOperationType,
   output logic [2:0]       aluOperation,
   input  logic [WIDTH-1:0] aluResult,
   input  logic             aluCarryOut,
   input  logic             aluZeroOut,
   input  logic             aluNegativeOut
);

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       work_type, work_op;
   logic [WIDTH-1:0] work_a, work_b;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             shift_go;
   logic             zero_shift;

   assign accept     = cmdValid & cmdReady;
   assign zero_shift = (cmdType == `SHIFT_OP) && (cmdCount == '0);
   assign shift_go   = (cmdType == `SHIFT_OP) && (cmdCount != '0);

   // ALU inputs come straight from the working registers; they are only
   // meaningful in EXEC/SHIFT.
   assign aluOperand1      = work_a;
   assign aluOperand2      = work_b;
   assign aluCarryIn       = flagC;
   assign aluOperationType = work_type;
   assign aluOperation     = work_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmdReady  = 1'b0;
      resValid  = 1'b0;
      case (state)
         IDLE: begin
            cmdReady = 1'b1;
            if (cmdValid) state_nxt = shift_go ? SHIFT : EXEC;
         end
         EXEC:  state_nxt = DONE;
         // count is never 0 here; the last iteration is count==1
         SHIFT: if (count <= 1) state_nxt = DONE;
         DONE: begin
            resValid = 1'b1;
`ifdef K16_SEQ_BACKTOBACK_EN
            cmdReady = resReady;
            if (resReady) begin
               if (cmdValid) state_nxt = shift_go ? SHIFT : EXEC;
               else          state_nxt = IDLE;
            end
`else
            if (resReady) state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_type <= '0;
         work_op   <= '0;
         work_a    <= '0;
         work_b    <= '0;
         count     <= '0;
         result    <= '0;
         flagC     <= 1'b0;
         flagZ     <= 1'b0;
         flagN     <= 1'b0;
      end else begin
         // accept only happens in IDLE/DONE, so it never collides with the
         // EXEC/SHIFT updates below
         if (accept) begin
            work_a <= cmdA;
            work_b <= cmdB;
            count  <= cmdCount;
            // a zero-count shift degenerates into a copy of A through the ALU,
            // which reports Z/N and passes C through unchanged
            if (zero_shift) begin
               work_type <= `LOAD_OP;
               work_op   <= `COPY_OP;
            end else begin
               work_type <= cmdType;
               work_op   <= cmdOp;
            end
            if (cmdCarryLoad) flagC <= cmdCarry;
         end
         case (state)
            EXEC: begin
               result <= aluResult;
               flagC  <= aluCarryOut;
               flagZ  <= aluZeroOut;
               flagN  <= aluNegativeOut;
            end
            SHIFT: begin
               work_a <= aluResult;
               flagC  <= aluCarryOut;
               count  <= count - 1'b1;
               if (count <= 1) begin
                  result <= aluResult;
                  flagZ  <= aluZeroOut;
                  flagN  <= aluNegativeOut;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_k16_alu_sequencer.sv
// Scoreboard bench for k16_alu_sequencer with a behavioural K16Alu model.
`timescale 1ns/1ps

`ifndef ALU_OP
`define ALU_OP   3'd0
`endif
`ifndef SHIFT_OP
`define SHIFT_OP 3'd1
`endif
`ifndef LOAD_OP
`define LOAD_OP  3'd2
`endif
`ifndef COPY_OP
`define COPY_OP  3'd0
`endif

module tb_k16_alu_sequencer;
   localparam int W = 16;
   localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, AND_ = 3'd4, XOR_ = 3'd6;
   localparam logic [2:0] SHL = 3'd0, SHR = 3'd1, ROL = 3'd2, ROR = 3'd3;
`ifdef K16_SEQ_BACKTOBACK_EN
   localparam int STREAM_NS = 20;
`else
   localparam int STREAM_NS = 30;
`endif

   logic clk = 0, reset = 1;
   logic cmdValid = 0, cmdReady;
   logic [2:0] cmdType = 0, cmdOp = 0;
   logic [W-1:0] cmdA = 0, cmdB = 0;
   logic [3:0] cmdCount = 0;
   logic cmdCarryLoad = 0, cmdCarry = 0;
   logic resValid, resReady = 1;
   logic [W-1:0] result;
   logic flagC, flagZ, flagN;
   logic [W-1:0] aluOperand1, aluOperand2, aluResult;
   logic aluCarryIn, aluCarryOut, aluZeroOut, aluNegativeOut;
   logic [2:0] aluOperationType, aluOperation;

   always #5 clk = ~clk;

   k16_alu_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdType(cmdType), .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
      .cmdCount(cmdCount), .cmdCarryLoad(cmdCarryLoad), .cmdCarry(cmdCarry),
      .resValid(resValid), .resReady(resReady), .result(result),
      .flagC(flagC), .flagZ(flagZ), .flagN(flagN),
      .aluOperand1(aluOperand1), .aluOperand2(aluOperand2),
      .aluCarryIn(aluCarryIn), .aluOperationType(aluOperationType),
      .aluOperation(aluOperation), .aluResult(aluResult),
      .aluCarryOut(aluCarryOut), .aluZeroOut(aluZeroOut),
      .aluNegativeOut(aluNegativeOut));

   // behavioural K16Alu
   always_comb begin
      logic [W:0] s;
      s = '0;
      aluResult   = aluOperand1;
      aluCarryOut = aluCarryIn;
      case (aluOperationType)
         `ALU_OP: case (aluOperation)
            ADD:  begin s = {1'b0, aluOperand1} + {1'b0, aluOperand2}; aluResult = s[W-1:0]; aluCarryOut = s[W]; end
            ADC:  begin s = {1'b0, aluOperand1} + {1'b0, aluOperand2} + {{W{1'b0}}, aluCarryIn};
                        aluResult = s[W-1:0]; aluCarryOut = s[W]; end
            AND_: aluResult = aluOperand1 & aluOperand2;
            XOR_: aluResult = aluOperand1 ^ aluOperand2;
            default: aluResult = aluOperand1 | aluOperand2;
         endcase
         `SHIFT_OP: case (aluOperation)
            SHL: begin aluResult = {aluOperand1[W-2:0], 1'b0};       aluCarryOut = aluOperand1[W-1]; end
            SHR: begin aluResult = {1'b0, aluOperand1[W-1:1]};       aluCarryOut = aluOperand1[0];   end
            ROL: begin aluResult = {aluOperand1[W-2:0], aluCarryIn}; aluCarryOut = aluOperand1[W-1]; end
            default: begin aluResult = {aluCarryIn, aluOperand1[W-1:1]}; aluCarryOut = aluOperand1[0]; end
         endcase
         default: aluResult = aluOperand1;
      endcase
      aluZeroOut     = (aluResult == '0);
      aluNegativeOut = aluResult[W-1];
   end

   typedef struct {
      logic [W-1:0] r;
      logic c, z, n;
      int lat;
      time acc;
   } exp_t;

   exp_t sb[$];
   time  hand_q[$];
   int   tests = 0, fails = 0;
   bit   seen = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: latency on first sight of resValid, data on handoff
   always @(negedge clk) begin
      exp_t e;
      if (resValid) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got %0h expected none", result);
         end else begin
            if (!seen) begin
               seen = 1;
               check("latency", int'(($time - sb[0].acc + 5) / 10), sb[0].lat);
            end
            if (resReady) begin
               e = sb.pop_front();
               check("result", result, e.r);
               check("flagC", flagC, e.c);
               check("flagZ", flagZ, e.z);
               check("flagN", flagN, e.n);
               hand_q.push_back($time);
               seen = 0;
            end
         end
      end
   end

   task automatic issue(input logic [2:0] t, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] cnt, input logic cl, input logic c,
                        input logic [W-1:0] er, input logic ec, input logic ez,
                        input logic en, input int elat);
      exp_t e;
      bit   done = 0;
      int   k = 0;
      @(negedge clk);
      cmdType = t; cmdOp = op; cmdA = a; cmdB = b; cmdCount = cnt;
      cmdCarryLoad = cl; cmdCarry = c; cmdValid = 1;
      while (!done) begin
         #1;
         if (cmdReady) begin
            @(posedge clk);
            e.r = er; e.c = ec; e.z = ez; e.n = en; e.lat = elat; e.acc = $time;
            sb.push_back(e);
            done = 1;
         end else begin
            @(negedge clk);
            k++;
            if (k > 50) begin
               tests++; fails++;
               $display("FAIL accept_timeout: got cmdReady=0 expected 1");
               done = 1;
            end
         end
      end
      #1 cmdValid = 0; cmdCarryLoad = 0;
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || resValid) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_cmdReady", cmdReady, 1);
      check("rst_resValid", resValid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {flagC, flagZ, flagN}, 0);
      check("rst_alu", {aluOperand1, aluOperand2, aluCarryIn, aluOperationType, aluOperation}, 0);
      reset = 0;

      // arithmetic and carry chain
      issue(`ALU_OP, ADC, 16'h000A, 16'h000F, 0, 1, 1, 16'h001A, 0, 0, 0, 2);
      issue(`ALU_OP, ADD, 16'hF000, 16'h1243, 0, 1, 0, 16'h0243, 1, 0, 0, 2);
      issue(`ALU_OP, ADC, 16'h0001, 16'h0000, 0, 0, 0, 16'h0002, 0, 0, 0, 2);
      drain();

      // iterated shifts
      issue(`SHIFT_OP, SHL, 16'h8234, 0, 1, 0, 0, 16'h0468, 1, 0, 0, 2);
      issue(`SHIFT_OP, SHL, 16'h8234, 0, 4, 0, 0, 16'h2340, 0, 0, 0, 5);
      issue(`SHIFT_OP, ROL, 16'h8235, 0, 2, 1, 0, 16'h08D5, 0, 0, 0, 3);
      // set C=1, then a zero-count shift must leave it alone
      issue(`ALU_OP, ADD, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 0, 2);
      issue(`SHIFT_OP, SHR, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 2);
      drain();

      // hold in DONE with a competing command
      resReady = 0;
      issue(`ALU_OP, ADD, 16'h7FFF, 16'h0001, 0, 1, 0, 16'h8000, 0, 0, 1, 2);
      begin
         int k = 0;
         while (!resValid && k < 20) begin @(negedge clk); k++; end
      end
      cmdType = `ALU_OP; cmdOp = XOR_; cmdA = 16'h1234; cmdB = 16'h00FF; cmdValid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_result", result, 16'h8000);
         check("hold_flags", {flagC, flagZ, flagN}, 3'b001);
         check("hold_cmdReady", cmdReady, 0);
         check("hold_resValid", resValid, 1);
      end
      cmdValid = 0;
      resReady = 1;
      drain();

      // stream throughput
      hand_q.delete();
      issue(`ALU_OP, ADD, 16'h0001, 16'h0001, 0, 1, 0, 16'h0002, 0, 0, 0, 2);
      issue(`ALU_OP, ADD, 16'h0002, 16'h0003, 0, 0, 0, 16'h0005, 0, 0, 0, 2);
      issue(`ALU_OP, ADC, 16'h0010, 16'h0020, 0, 0, 0, 16'h0030, 0, 0, 0, 2);
      issue(`ALU_OP, ADD, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'hFFFE, 1, 0, 1, 2);
      drain();
      check("stream_count", hand_q.size(), 4);
      if (hand_q.size() == 4)
         for (int i = 1; i < 4; i++)
            check("stream_interval", int'(hand_q[i] - hand_q[i-1]), STREAM_NS);

      // reset during a long shift
      @(negedge clk);
      cmdType = `SHIFT_OP; cmdOp = SHL; cmdA = 16'h0001; cmdCount = 10; cmdValid = 1;
      @(posedge clk);
      #1 cmdValid = 0;
      repeat (3) @(posedge clk);
      #2 reset = 1;
      #1;
      check("abort_cmdReady", cmdReady, 1);
      check("abort_resValid", resValid, 0);
      check("abort_result", result, 0);
      check("abort_flags", {flagC, flagZ, flagN}, 0);
      check("abort_alu", {aluOperand1, aluOperand2, aluCarryIn, aluOperationType, aluOperation}, 0);
      @(negedge clk);
      reset = 0;

      issue(`ALU_OP, ADD, 16'h0003, 16'h0004, 0, 0, 0, 16'h0007, 0, 0, 0, 2);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
